// File: rtl/hazard_forward_ctrl.sv
// ID/EX hazard controller: operand forwarding selects, load-use stall/bubble,
// branch flush, memory-wait freeze and a saturating stall-cycle counter.
module hazard_forward_ctrl #(
    parameter int unsigned RA_W  = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [1:0]       id_op1,
    input  logic [RA_W-1:0]  id_op2,
    input  logic [RA_W-1:0]  id_cond,
    input  logic [3:0]       id_op3,
    input  logic             ex_br_taken,
    input  logic             mem_wait,
    output logic             stall_ifid,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EXM = 2'b01;
    localparam logic [1:0] SEL_MWB = 2'b10;

    typedef enum logic {RUN, LUSTALL} state_t;

    typedef struct packed {
        logic            valid;
        logic            wr;
        logic            ld;
        logic [RA_W-1:0] dest;
    } hist_t;

    state_t state_q;
    hist_t  e_q;
    hist_t  m_q;
    hist_t  id_ent;

    logic dec_alu;
    logic dec_ld;
    logic dec_st;
    logic dec_br;
    logic dec_wr;
    logic dec_rda;
    logic dec_rdb;
    logic load_use;
    logic [1:0] sel_a;
    logic [1:0] sel_b;

    // EX result wins over MEM; a load still in EX cannot forward yet.
    function automatic logic [1:0] fwd_pick(input logic rd, input logic [RA_W-1:0] src,
                                            input hist_t e, input hist_t m);
        logic [1:0] sel;
        sel = SEL_RF;
        if (rd) begin
            if (e.valid && e.wr && e.dest == src)
                sel = SEL_EXM;
            else if (m.valid && (m.wr || m.ld) && m.dest == src)
                sel = SEL_MWB;
        end
        return sel;
    endfunction

    // Decode of the instruction currently in ID
    always_comb begin
        dec_alu = (id_op1 == 2'b11);
        dec_ld  = (id_op1 == 2'b00);
        dec_st  = (id_op1 == 2'b01);
        dec_br  = (id_op1 == 2'b10);
        dec_wr  = (dec_alu && id_op3 <= 4'd12 && id_op3 != 4'd5 && id_op3 != 4'd7)
                || (dec_br && id_op2 == RA_W'(1));
        dec_rda = (dec_alu && (id_op3 <= 4'd6 || id_op3 == 4'd13)) || dec_st;
        dec_rdb = (dec_alu && (id_op3 <= 4'd5 || (id_op3 >= 4'd8 && id_op3 <= 4'd11)))
                || dec_ld || dec_st
                || (dec_br && (id_op2 == RA_W'(1) || id_op2 == RA_W'(2) || id_op2 == RA_W'(6)));

        id_ent.valid = id_valid;
        id_ent.wr    = dec_wr;
        id_ent.ld    = dec_ld;
        id_ent.dest  = dec_ld ? id_op2 : id_cond;

        load_use = id_valid && e_q.valid && e_q.ld
                && ((dec_rda && e_q.dest == id_op2) || (dec_rdb && e_q.dest == id_cond));

        sel_a = fwd_pick(id_valid && dec_rda, id_op2, e_q, m_q);
        sel_b = fwd_pick(id_valid && dec_rdb, id_cond, e_q, m_q);
    end

    assign stall_ifid = !reset
                     && (mem_wait || (state_q == RUN && !ex_br_taken && load_use));

    // Pipeline history, FSM and registered outputs; mem_wait freezes everything
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            e_q       <= '0;
            m_q       <= '0;
            bubble_ex <= 1'b1;
            fwd_a_sel <= SEL_RF;
            fwd_b_sel <= SEL_RF;
            stall_cnt <= '0;
        end else if (!mem_wait) begin
            m_q <= e_q;
            if (ex_br_taken) begin
                state_q   <= RUN;
                e_q       <= '0;
                bubble_ex <= 1'b1;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
            end else if (state_q == RUN && load_use) begin
                state_q   <= LUSTALL;
                e_q       <= '0;
                bubble_ex <= 1'b1;
                fwd_a_sel <= SEL_RF;
                fwd_b_sel <= SEL_RF;
                if (stall_cnt != {CNT_W{1'b1}})
                    stall_cnt <= stall_cnt + CNT_W'(1);
            end else begin
                state_q   <= RUN;
                e_q       <= id_ent;
                bubble_ex <= !id_valid;
                fwd_a_sel <= sel_a;
                fwd_b_sel <= sel_b;
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed scenarios plus a
// randomized run compared against a table-driven pipeline model.
module tb_hazard_forward_ctrl;

    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_valid = 1'b0;
    logic [1:0] id_op1 = 2'b00;
    logic [2:0] id_op2 = 3'd0;
    logic [2:0] id_cond = 3'd0;
    logic [3:0] id_op3 = 4'd0;
    logic       ex_br_taken = 1'b0;
    logic       mem_wait = 1'b0;
    logic       stall_ifid;
    logic       bubble_ex;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    hazard_forward_ctrl #(.RA_W(3), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_op1(id_op1),
        .id_op2(id_op2), .id_cond(id_cond), .id_op3(id_op3),
        .ex_br_taken(ex_br_taken), .mem_wait(mem_wait), .stall_ifid(stall_ifid),
        .bubble_ex(bubble_ex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    // Reference model: issued-instruction list, hist[0] = EX, hist[1] = MEM
    typedef struct {
        bit       v;
        bit       wr;
        bit       ld;
        bit [2:0] dest;
    } ent_t;

    ent_t hist[2];
    bit   m_after_stall;
    bit   m_bubble;
    bit [1:0] m_fa, m_fb;
    int   m_cnt;
    bit   exp_stall, obs_stall;

    localparam bit [15:0] ALU_WR_MASK = 16'h1F5F;
    localparam bit [15:0] ALU_RA_MASK = 16'h207F;
    localparam bit [15:0] ALU_RB_MASK = 16'h0F3F;
    localparam bit [7:0]  BR_RB_MASK  = 8'h46;

    function automatic bit [1:0] producer_of(input bit [2:0] src);
        if (hist[0].v && hist[0].wr && hist[0].dest == src) return 2'd1;
        if (hist[1].v && (hist[1].wr || hist[1].ld) && hist[1].dest == src) return 2'd2;
        return 2'd0;
    endfunction

    // One clock: drive, sample stall mid-cycle, advance model, land #1 after edge
    task automatic tick(input bit rst, input bit v, input bit [1:0] o1, input bit [2:0] o2,
                        input bit [2:0] c, input bit [3:0] o3, input bit br, input bit mw);
        bit wr, ld, rda, rdb, hz;
        ent_t nx;
        reset = rst; id_valid = v; id_op1 = o1; id_op2 = o2; id_cond = c; id_op3 = o3;
        ex_br_taken = br; mem_wait = mw;
        wr  = (o1 == 2'd3 && ALU_WR_MASK[o3]) || (o1 == 2'd2 && o2 == 3'd1);
        ld  = (o1 == 2'd0);
        rda = (o1 == 2'd3 && ALU_RA_MASK[o3]) || o1 == 2'd1;
        rdb = (o1 == 2'd3 && ALU_RB_MASK[o3]) || o1 == 2'd0 || o1 == 2'd1
            || (o1 == 2'd2 && BR_RB_MASK[o2]);
        hz  = v && hist[0].v && hist[0].ld
            && ((rda && hist[0].dest == o2) || (rdb && hist[0].dest == c));
        exp_stall = !rst && (mw || (!m_after_stall && !br && hz));
        #3;
        obs_stall = stall_ifid;
        @(posedge clock);
        #1;
        if (rst) begin
            hist[0] = '{default: 0}; hist[1] = '{default: 0};
            m_after_stall = 0; m_bubble = 1; m_fa = 0; m_fb = 0; m_cnt = 0;
        end else if (!mw) begin
            nx = '{v: v, wr: wr, ld: ld, dest: ld ? o2 : c};
            if (br || (hz && !m_after_stall)) begin
                m_after_stall = !br;
                if (!br && m_cnt < CNT_MAX) m_cnt++;
                m_fa = 0; m_fb = 0; m_bubble = 1;
                nx = '{default: 0};
            end else begin
                m_after_stall = 0;
                m_fa = (v && rda) ? producer_of(o2) : 2'd0;
                m_fb = (v && rdb) ? producer_of(c) : 2'd0;
                m_bubble = !v;
            end
            hist[1] = hist[0];
            hist[0] = nx;
        end
    endtask

    task automatic test_reset;
        tick(1, 1, 2'd3, 3'd1, 3'd2, 4'd0, 0, 0);
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", obs_stall); end
        checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL reset_bubble got %b want 1", bubble_ex); end
        checks++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL reset_sels got %b%b want 0000", fwd_a_sel, fwd_b_sel); end
        checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_fwd_ex;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 2'd3, 3'd0, 3'd3, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd3, 3'd0, 4'd0, 0, 0);
        checks++; if (fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_ex_a got %b want 01", fwd_a_sel); end
        checks++; if (fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fwd_ex_b got %b want 00", fwd_b_sel); end
        checks++; if (bubble_ex !== 1'b0) begin errors++; $display("FAIL fwd_ex_bubble got %b want 0", bubble_ex); end
    endtask

    task automatic test_fwd_mem;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 2'd3, 3'd0, 3'd3, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd5, 3'd6, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd7, 3'd3, 4'd0, 0, 0);
        checks++; if (fwd_b_sel !== 2'b10) begin errors++; $display("FAIL fwd_mem_b got %b want 10", fwd_b_sel); end
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 2'd3, 3'd0, 3'd3, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd0, 3'd3, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd7, 3'd3, 4'd0, 0, 0);
        checks++; if (fwd_b_sel !== 2'b01) begin errors++; $display("FAIL fwd_ex_over_mem got %b want 01", fwd_b_sel); end
    endtask

    task automatic test_load_use;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 2'd0, 3'd2, 3'd0, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 0);
        checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", obs_stall); end
        checks++; if (bubble_ex !== 1'b1 || fwd_a_sel !== 2'b00) begin errors++; $display("FAIL lu_bubble got %b/%b want 1/00", bubble_ex, fwd_a_sel); end
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt got %0d want 1", stall_cnt); end
        tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 0);
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b want 0", obs_stall); end
        checks++; if (fwd_a_sel !== 2'b10 || bubble_ex !== 1'b0) begin errors++; $display("FAIL lu_fwd got %b/%b want 10/0", fwd_a_sel, bubble_ex); end
        checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL lu_cnt_hold got %0d want 1", stall_cnt); end
    endtask

    task automatic test_flush_beats_lu;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 2'd0, 3'd2, 3'd0, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 1, 0);
        checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", obs_stall); end
        checks++; if (bubble_ex !== 1'b1 || {fwd_a_sel, fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL flush_out got %b/%b%b want 1/0000", bubble_ex, fwd_a_sel, fwd_b_sel); end
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL flush_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_freeze;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 2'd0, 3'd2, 3'd0, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 1);
            checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL freeze_stall[%0d] got %b want 1", i, obs_stall); end
            checks++; if ({bubble_ex, fwd_a_sel, fwd_b_sel} !== 5'b10000 || stall_cnt !== 8'd1) begin
                errors++; $display("FAIL freeze_hold[%0d] got %b%b%b cnt %0d want 10000 cnt 1", i, bubble_ex, fwd_a_sel, fwd_b_sel, stall_cnt); end
        end
        tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 0);
        checks++; if (obs_stall !== 1'b0 || fwd_a_sel !== 2'b10 || stall_cnt !== 8'd1) begin
            errors++; $display("FAIL freeze_release got stall %b sel %b cnt %0d want 0 10 1", obs_stall, fwd_a_sel, stall_cnt); end
    endtask

    task automatic test_reset_mid_stall;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 1, 2'd0, 3'd2, 3'd0, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 0);
        tick(1, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 0);
        tick(0, 1, 2'd3, 3'd2, 3'd4, 4'd0, 0, 0);
        checks++; if (obs_stall !== 1'b0 || fwd_a_sel !== 2'b00 || stall_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_mid_stall got stall %b sel %b cnt %0d want 0 00 0", obs_stall, fwd_a_sel, stall_cnt); end
    endtask

    task automatic test_saturation;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1 + 2 * CNT_MAX; i++) tick(0, 1, 2'd0, 3'd2, 3'd2, 4'd0, 0, 0);
        checks++; if (stall_cnt !== 8'(CNT_MAX)) begin errors++; $display("FAIL sat_reach got %0d want %0d", stall_cnt, CNT_MAX); end
        for (int i = 0; i < 6; i++) tick(0, 1, 2'd0, 3'd2, 3'd2, 4'd0, 0, 0);
        checks++; if (stall_cnt !== 8'(CNT_MAX)) begin errors++; $display("FAIL sat_hold got %0d want %0d", stall_cnt, CNT_MAX); end
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL sat_clear got %0d want 0", stall_cnt); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(99) == 0, $urandom_range(7) != 0, 2'($urandom_range(3)),
                 3'($urandom_range(3)), 3'($urandom_range(3)), 4'($urandom_range(15)),
                 $urandom_range(9) == 0, $urandom_range(7) == 0);
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d got %b want %b", i, obs_stall, exp_stall); end
            checks++; if (bubble_ex !== m_bubble) begin errors++; $display("FAIL rnd_bubble@%0d got %b want %b", i, bubble_ex, m_bubble); end
            checks++; if (fwd_a_sel !== m_fa || fwd_b_sel !== m_fb) begin
                errors++; $display("FAIL rnd_sels@%0d got %b/%b want %b/%b", i, fwd_a_sel, fwd_b_sel, m_fa, m_fb); end
            checks++; if (stall_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL rnd_cnt@%0d got %0d want %0d", i, stall_cnt, m_cnt); end
        end
    endtask

    initial begin
        @(posedge clock);
        #1;
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_flush_beats_lu();
        test_freeze();
        test_reset_mid_stall();
        test_saturation();
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
